mult_hilo_ctrl: RTL and testbench
=================================

# mult_hilo_ctrl

Issue and writeback controller in front of the iterative `multiply` unit. It accepts multiply requests over a valid/ready handshake and drives `mult_begin`, `mult_op1` and `mult_op2` with the level-hold protocol that `multiply` requires. It captures the 64-bit `product` into architectural HI/LO registers and services direct HI/LO writes (MTHI/MTLO). It sits between the execute-stage decode and `multiply`, and its HI/LO outputs feed the MFHI/MFLO result mux.

## Interface
- `TIMEOUT`, default 40: cycles in RUN without `mult_end` before the operation is aborted.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: multiply request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_acc` in 1: accumulate request (MADD); honoured only with `MULT_ACC_EN`.
- `req_op1` in 32: first operand.
- `req_op2` in 32: second operand.
- `wr_hi_en` in 1: write `wr_data` to HI.
- `wr_lo_en` in 1: write `wr_data` to LO.
- `wr_data` in 32: HI/LO write data.
- `mult_begin` out 1: to `multiply`; held high for the whole operation.
- `mult_op1` out 32: registered operand to `multiply`.
- `mult_op2` out 32: registered operand to `multiply`.
- `product` in 64: from `multiply`.
- `mult_end` in 1: from `multiply`; completion level.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse, HI/LO updated by a multiply.
- `timeout` out 1: one-cycle pulse, operation aborted.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:** `req_ready` = 1.
  - `req_valid` & `req_ready` at an edge latches `req_op1/op2` into `mult_op1/op2` and latches `req_acc`.
  - The next state is RUN.
- **RUN:**
  - `mult_begin` = 1, and `mult_op1/op2` are stable.
  - The watchdog counter increments each cycle.
  - When `mult_end` = 1 is sampled, `{hi,lo}` is loaded at that edge, and the next state is DRAIN.
  - The loaded value is `product`, or `{hi,lo}` + `product` (mod 2^64) when accumulate is active.
  - If the counter reaches `TIMEOUT` first, the next state is DRAIN, HI/LO are unchanged and `timeout` pulses.
- **DRAIN:**
  - `mult_begin` = 0.
  - Wait for `mult_end` = 0 (or one cycle if already 0), then go to IDLE.
  - This guarantees `multiply` has reset before the next begin.
- **HI/LO writes:**
  - Accepted only in IDLE. In RUN/DRAIN they are ignored, because decode stalls on `busy`.
  - `wr_hi_en` and `wr_lo_en` together write both registers.
- **Simultaneous write and request in IDLE:** both take effect. The write lands in that same edge, and any later accumulate uses the written value.
- **Reset:** from any state, the next state is IDLE.
  - Outputs after reset: `hi`=0, `lo`=0, `mult_begin`=0, `mult_op1`=0, `mult_op2`=0, `done`=0, `timeout`=0, `busy`=0, `req_ready`=1.
  - Reset mid-operation drops `mult_begin` on the next cycle, and no `done` is produced.

## Timing
- Accept edge T0. `mult_begin` is high from T0+1.
- `mult_end` is sampled high at edge Tn. HI/LO hold the new value after Tn, and `done` is high in the cycle after Tn.
- `mult_begin` is low in the cycle after Tn.
- `req_ready` returns one cycle after `mult_end` falls. Minimum spacing between back-to-back requests is `multiply` latency + 3 cycles.
- `done` and `timeout` are never high together.
- The watchdog counter is sized as clog2(`TIMEOUT`+1) and cleared on accept.

## Configuration
- **`MULT_ACC_EN` defined:** `req_acc` selects accumulate. A full 64-bit add is performed in the capture cycle, and the carry out of bit 63 is discarded.
- **`MULT_ACC_EN` undefined:** `req_acc` is ignored, `product` is always loaded directly, and no adder is instantiated.

## Structure
- **Shared package `mult_pkg`:**
  - state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - `MULT_W`=32 and `PROD_W`=64.
  - default `TIMEOUT`.
- **Sub-module `hilo_regs`:** the HI/LO register pair with its write and capture muxing, plus the optional accumulate adder. The FSM and watchdog stay in the top level.

## Test plan
- **Basic capture:** request 0x00001111 × 0x00001111 with the real `multiply` → `hi`=0x00000000, `lo`=0x01234321, one `done` pulse, `mult_begin` high from T0+1 until the cycle after `mult_end`.
- **Back-to-back:** 0x00001111 × 0x00002222 issued with `req_valid` held high → `lo`=0x02468642. The second request is not accepted until DRAIN completes, and `mult_begin` shows at least one low cycle between operations.
- **Accumulate (`MULT_ACC_EN`):** MTHI 0, MTLO 0xFFFFFFFF, then MADD 1 × 1 → `hi`=0x00000001, `lo`=0x00000000. Without the macro, the same stimulus gives `lo`=0x00000001.
- **Timeout:** a stub that never raises `mult_end` → `timeout` pulses exactly `TIMEOUT` cycles after entering RUN, HI/LO keep their prior values, and `req_ready` returns.
- **Write during busy:** `wr_lo_en` with 0xDEADBEEF while in RUN → ignored, and `lo` equals the multiply result afterward.
- **Reset mid-op:** `rst` pulsed in RUN → `mult_begin`=0 the next cycle, `hi`=`lo`=0, no `done`, and the next request completes normally.

Source files
------------

// File: rtl/mult_pkg.sv
// +-----------------------------------------------------------------------------
// | mult_pkg : shared widths, default watchdog limit and FSM encoding
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int MULT_W      = 32;
  localparam int PROD_W      = 64;
  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hilo_regs.sv
// +-----------------------------------------------------------------------------
// | hilo_regs : HI/LO register pair with MTHI/MTLO writes and product capture;
// |             accumulate adder present only when MULT_ACC_EN is defined
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module hilo_regs
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_hi_en_i,
  input  logic              wr_lo_en_i,
  input  logic [MULT_W-1:0] wr_data_i,
  input  logic              cap_en_i,
  input  logic              acc_en_i,
  input  logic [PROD_W-1:0] product_i,
  output logic [MULT_W-1:0] hi_o,
  output logic [MULT_W-1:0] lo_o
);

  logic [MULT_W-1:0] hi_q, hi_d;
  logic [MULT_W-1:0] lo_q, lo_d;
  logic [PROD_W-1:0] w_cap_val;

`ifdef MULT_ACC_EN
  // Carry out of bit 63 falls off the 64-bit sum.
  assign w_cap_val = acc_en_i ? ({hi_q, lo_q} + product_i) : product_i;
`else
  logic unused_acc;
  assign unused_acc = acc_en_i;
  assign w_cap_val  = product_i;
`endif

  // Capture and writes are mutually exclusive by construction (RUN vs IDLE).
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en_i) begin
      {hi_d, lo_d} = w_cap_val;
    end else begin
      if (wr_hi_en_i) hi_d = wr_data_i;
      if (wr_lo_en_i) lo_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
// +-----------------------------------------------------------------------------
// | mult_hilo_ctrl : issue/writeback controller for the iterative multiplier,
// |                  HI/LO owner; MULT_ACC_EN enables MADD accumulate
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_acc,
  input  logic [MULT_W-1:0] req_op1,
  input  logic [MULT_W-1:0] req_op2,
  input  logic              wr_hi_en,
  input  logic              wr_lo_en,
  input  logic [MULT_W-1:0] wr_data,
  output logic              mult_begin,
  output logic [MULT_W-1:0] mult_op1,
  output logic [MULT_W-1:0] mult_op2,
  input  logic [PROD_W-1:0] product,
  input  logic              mult_end,
  output logic [MULT_W-1:0] hi,
  output logic [MULT_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MULT_W-1:0] op1_q, op1_d;
  logic [MULT_W-1:0] op2_q, op2_d;
  logic              acc_q, acc_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              w_capture;
  logic              w_idle;

  assign w_idle = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    w_capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op1_d   = req_op1;
          op2_d   = req_op2;
          acc_d   = req_acc;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mult_end) begin
          w_capture = 1'b1;
          done_d    = 1'b1;
          state_d   = DRAIN;
        end else if (cnt_d == CNT_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Multiplier must see begin low and drop end before the next issue.
        if (!mult_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  hilo_regs u_hilo_regs (
    .clk        (clk),
    .rst        (rst),
    .wr_hi_en_i (wr_hi_en & w_idle),
    .wr_lo_en_i (wr_lo_en & w_idle),
    .wr_data_i  (wr_data),
    .cap_en_i   (w_capture),
    .acc_en_i   (acc_q),
    .product_i  (product),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  assign req_ready  = w_idle;
  assign busy       = !w_idle;
  assign mult_begin = (state_q == RUN);
  assign mult_op1   = op1_q;
  assign mult_op2   = op2_q;
  assign done       = done_q;
  assign timeout    = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
// +-----------------------------------------------------------------------------
// | tb_mult_hilo_ctrl : scoreboard bench with a behavioural multiplier stub
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mult_hilo_ctrl;

  localparam int TMO = 40;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_acc = 1'b0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic        wr_hi_en = 1'b0;
  logic        wr_lo_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mult_end = 1'b0;
  logic [63:0] product = '0;
  logic        req_ready, mult_begin, busy, done, timeout;
  logic [31:0] mult_op1, mult_op2, hi, lo;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_acc    (req_acc),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .wr_hi_en   (wr_hi_en),
    .wr_lo_en   (wr_lo_en),
    .wr_data    (wr_data),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic        stub_hang = 1'b0;
  int          stub_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] model_hilo = '0;

  always @(posedge clk) cyc++;

  // Multiplier stub: end rises LAT cycles into begin, falls once begin drops.
  always @(posedge clk) begin
    if (!mult_begin) begin
      stub_cnt <= 0;
      mult_end <= 1'b0;
    end else if (!stub_hang) begin
      product <= {32'b0, mult_op1} * {32'b0, mult_op2};
      if (stub_cnt == LAT - 1) mult_end <= 1'b1;
      else stub_cnt <= stub_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done || timeout) begin
        n_checks++;
        if (done && timeout) begin
          n_errors++;
          $display("FAIL done_timeout_overlap done=%b timeout=%b required not both", done, timeout);
        end
      end
      if (done) begin
        done_cnt++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done hilo=%h required no done", {hi, lo});
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          if ({hi, lo} !== e) begin
            n_errors++;
            $display("FAIL sb_hilo got=%h exp=%h", {hi, lo}, e);
          end
        end
      end
    end
  end

  function automatic logic [63:0] expect_of(input logic [63:0] cur, input logic [31:0] a,
                                            input logic [31:0] b, input logic acc);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
`ifdef MULT_ACC_EN
    return acc ? cur + p : p;
`else
    return p;
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic acc,
                       input bit push, output int t0);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_op1 = a; req_op2 = b; req_acc = acc;
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    if (!req_ready) begin
      n_checks++; n_errors++;
      $display("FAIL issue_wait req_ready=%b required 1", req_ready);
      req_valid = 1'b0; t0 = -1;
      return;
    end
    if (push) begin
      model_hilo = expect_of(model_hilo, a, b, acc);
      sb_q.push_back(model_hilo);
    end
    @(negedge clk);
    req_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic hilo_write(input logic he, input logic le, input logic [31:0] d);
    @(negedge clk);
    wr_hi_en = he; wr_lo_en = le; wr_data = d;
    @(negedge clk);
    wr_hi_en = 1'b0; wr_lo_en = 1'b0;
    if (he) model_hilo[63:32] = d;
    if (le) model_hilo[31:0]  = d;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (done !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    if (done !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL done_wait done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hi, lo} !== 64'h0) begin n_errors++; $display("FAIL rst_hilo got=%h exp=0", {hi, lo}); end
    n_checks++;
    if ({mult_begin, done, timeout, busy, req_ready} !== 5'b00001) begin
      n_errors++;
      $display("FAIL rst_ctl got=%b exp=00001", {mult_begin, done, timeout, busy, req_ready});
    end
    n_checks++;
    if ({mult_op1, mult_op2} !== 64'h0) begin
      n_errors++; $display("FAIL rst_ops got=%h exp=0", {mult_op1, mult_op2});
    end
    rst = 1'b0;
    model_hilo = '0;
    sb_q.delete();
  endtask

  task automatic test_writes();
    hilo_write(1'b1, 1'b1, 32'hA5A5_0F0F);
    n_checks++;
    if ({hi, lo} !== 64'hA5A5_0F0F_A5A5_0F0F) begin
      n_errors++; $display("FAIL wr_both got=%h exp=a5a50f0fa5a50f0f", {hi, lo});
    end
    hilo_write(1'b0, 1'b1, 32'h1234_5678);
    n_checks++;
    if ({hi, lo} !== 64'hA5A5_0F0F_1234_5678) begin
      n_errors++; $display("FAIL wr_lo got=%h exp=a5a50f0f12345678", {hi, lo});
    end
  endtask

  task automatic test_basic();
    int t0, w, d0;
    bit held;
    d0 = done_cnt;
    issue(32'h1111, 32'h1111, 1'b0, 1'b1, t0);
    n_checks++;
    if ({mult_begin, busy, req_ready} !== 3'b110) begin
      n_errors++; $display("FAIL basic_begin got=%b exp=110", {mult_begin, busy, req_ready});
    end
    n_checks++;
    if ({mult_op1, mult_op2} !== {32'h1111, 32'h1111}) begin
      n_errors++; $display("FAIL basic_ops got=%h exp=0000111100001111", {mult_op1, mult_op2});
    end
    held = 1'b1; w = 0;
    while (mult_end !== 1'b1 && w < 200) begin
      if (mult_begin !== 1'b1) held = 1'b0;
      @(negedge clk); w++;
    end
    n_checks++;
    if (!held || mult_begin !== 1'b1) begin
      n_errors++; $display("FAIL basic_hold held=%b begin=%b exp 1", held, mult_begin);
    end
    @(negedge clk);
    n_checks++;
    if ({done, mult_begin} !== 2'b10) begin
      n_errors++; $display("FAIL basic_done got=%b exp=10", {done, mult_begin});
    end
    n_checks++;
    if ({hi, lo} !== 64'h0000_0000_0123_4321) begin
      n_errors++; $display("FAIL basic_hilo got=%h exp=0000000001234321", {hi, lo});
    end
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, w, low_cnt;
    bit saw_done;
    @(negedge clk);
    req_valid = 1'b1; req_op1 = 32'h1111; req_op2 = 32'h2222; req_acc = 1'b0;
    model_hilo = expect_of(model_hilo, 32'h1111, 32'h2222, 1'b0);
    sb_q.push_back(model_hilo);
    @(negedge clk);
    t0 = cyc;
    req_op1 = 32'd3; req_op2 = 32'd7;
    low_cnt = 0; saw_done = 1'b0; w = 0;
    while (!req_ready && w < 200) begin
      if (done) begin
        saw_done = 1'b1;
        n_checks++;
        if (lo !== 32'h0246_8642) begin
          n_errors++; $display("FAIL b2b_first_lo got=%h exp=02468642", lo);
        end
      end
      if (!mult_begin) low_cnt++;
      @(negedge clk); w++;
    end
    if (!mult_begin) low_cnt++;
    n_checks++;
    if (!saw_done || low_cnt < 1 || (cyc + 1 - t0) < LAT + 3) begin
      n_errors++;
      $display("FAIL b2b_spacing done=%b low=%0d gap=%0d exp done=1 low>=1 gap>=%0d",
               saw_done, low_cnt, cyc + 1 - t0, LAT + 3);
    end
    model_hilo = expect_of(model_hilo, 32'd3, 32'd7, 1'b0);
    sb_q.push_back(model_hilo);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();
    n_checks++;
    if (lo !== 32'd21) begin n_errors++; $display("FAIL b2b_second_lo got=%h exp=15", lo); end
  endtask

  task automatic test_accumulate();
    int t0;
    logic [63:0] e;
    hilo_write(1'b1, 1'b0, 32'h0);
    hilo_write(1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(32'd1, 32'd1, 1'b1, 1'b1, t0);
    wait_done();
    n_checks++;
`ifdef MULT_ACC_EN
    e = 64'h0000_0001_0000_0000;
`else
    e = 64'h0000_0000_0000_0001;
`endif
    if ({hi, lo} !== e) begin n_errors++; $display("FAIL madd_hilo got=%h exp=%h", {hi, lo}, e); end
    // MTHI and MADD on the same edge: accumulate sees the written HI.
    @(negedge clk);
    wait (req_ready === 1'b1);
    @(negedge clk);
    wr_hi_en = 1'b1; wr_data = 32'd2;
    req_valid = 1'b1; req_op1 = 32'd3; req_op2 = 32'd4; req_acc = 1'b1;
    model_hilo[63:32] = 32'd2;
    model_hilo = expect_of(model_hilo, 32'd3, 32'd4, 1'b1);
    sb_q.push_back(model_hilo);
    @(negedge clk);
    wr_hi_en = 1'b0; req_valid = 1'b0; req_acc = 1'b0;
    wait_done();
    n_checks++;
    if ({hi, lo} !== model_hilo) begin
      n_errors++; $display("FAIL madd_simul got=%h exp=%h", {hi, lo}, model_hilo);
    end
  endtask

  task automatic test_write_busy();
    int t0;
    logic [63:0] prev;
    prev = {hi, lo};
    issue(32'h1234, 32'h10, 1'b0, 1'b1, t0);
    wr_lo_en = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_lo_en = 1'b0;
    n_checks++;
    if (lo !== prev[31:0]) begin
      n_errors++; $display("FAIL busy_write_lo got=%h exp=%h", lo, prev[31:0]);
    end
    wait_done();
    n_checks++;
    if (lo !== 32'h0001_2340) begin n_errors++; $display("FAIL busy_result_lo got=%h exp=00012340", lo); end
  endtask

  task automatic test_timeout();
    int t0, w, d0;
    logic [63:0] prev;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    prev = {hi, lo};
    d0 = done_cnt;
    stub_hang = 1'b1;
    issue(32'd5, 32'd6, 1'b0, 1'b0, t0);
    w = 0;
    while (timeout !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    n_checks++;
    if (timeout !== 1'b1 || cyc - t0 !== TMO) begin
      n_errors++; $display("FAIL tmo_cycle got=%0d exp=%0d", cyc - t0, TMO);
    end
    n_checks++;
    if ({hi, lo} !== prev || done_cnt !== d0) begin
      n_errors++; $display("FAIL tmo_hilo got=%h exp=%h dones=%0d", {hi, lo}, prev, done_cnt - d0);
    end
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    n_checks++;
    if (req_ready !== 1'b1) begin n_errors++; $display("FAIL tmo_ready got=%b exp=1", req_ready); end
    stub_hang = 1'b0;
  endtask

  task automatic test_reset_midop();
    int t0, d0;
    issue(32'd7, 32'd9, 1'b0, 1'b1, t0);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    model_hilo = '0;
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({mult_begin, done, req_ready} !== 3'b001 || {hi, lo} !== 64'h0) begin
      n_errors++;
      $display("FAIL rst_midop got begin/done/ready=%b hilo=%h exp 001 and 0",
               {mult_begin, done, req_ready}, {hi, lo});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0) begin n_errors++; $display("FAIL rst_midop_done got=%0d exp=0", done_cnt - d0); end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, t0);
    wait_done();
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_errors++; $display("FAIL rst_after_op got=%h exp=fffffffe00000001", {hi, lo});
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_basic();
    test_back_to_back();
    test_accumulate();
    test_write_busy();
    test_timeout();
    test_reset_midop();
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
